// File: rtl/scroll_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scroll_sequencer
// Description : Scroll-position generator for the sliding text display.
//               Produces the start character offset into the selected
//               message, the registered message select for the datapath MUX,
//               and step/wrap strobes. Supports a programmable step rate,
//               scroll direction, single-stepping while paused and a clean
//               restart whenever the requested message changes.
// Ports       : clk          system clock, all logic on the rising edge
//               rst          synchronous active-high reset
//               scroll_en    1 = free-running scroll, 0 = paused
//               sel_student  requested message (0 = A, 1 = B)
//               msg_len_a    character count of message A (0 = empty)
//               msg_len_b    character count of message B (0 = empty)
//               speed        rate select, step period = STEP_BASE >> speed
//               dir          0 = offset increments, 1 = offset decrements
//               step_pulse   single-cycle advance request while paused
//               offset       current start character index
//               msg_sel      registered message select
//               step_tick    1-cycle strobe with each new offset
//               wrap         1-cycle strobe when an advance wraps around
// Revision    : 1.0 - initial release
// ============================================================================
module scroll_sequencer #(
    parameter int unsigned STEP_BASE = 25_000_000,
    parameter int unsigned LEN_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scroll_en,
    input  logic             sel_student,
    input  logic [LEN_W-1:0] msg_len_a,
    input  logic [LEN_W-1:0] msg_len_b,
    input  logic [1:0]       speed,
    input  logic             dir,
    input  logic             step_pulse,
    output logic [LEN_W-1:0] offset,
    output logic             msg_sel,
    output logic             step_tick,
    output logic             wrap
);

    // Prescaler only has to hold values up to STEP_BASE-1.
    localparam int unsigned C_CNT_W = (STEP_BASE > 1) ? $clog2(STEP_BASE) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = 1;
    localparam logic [LEN_W-1:0]   C_LEN_ONE = 1;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t               r_state;
    logic [C_CNT_W-1:0]   r_cnt;

    state_t               w_nxt_state;
    logic [C_CNT_W-1:0]   w_nxt_cnt;
    logic [LEN_W-1:0]     w_nxt_offset;
    logic                 w_nxt_sel;
    logic                 w_nxt_tick;
    logic                 w_nxt_wrap;
    logic                 w_adv_req;

    logic [31:0]          w_period_m1;
    logic [31:0]          w_cnt_ext;
    logic                 w_terminal;

    logic [LEN_W-1:0]     w_len;
    logic [LEN_W-1:0]     w_len_m1;
    logic                 w_out_of_range;
    logic [LEN_W-1:0]     w_adv_offset;
    logic                 w_adv_wrap;

    // ------------------------------------------------------------------
    // Prescaler terminal detection. Using >= rather than == means a speed
    // increase that leaves cnt beyond the new period fires immediately
    // instead of running the counter all the way round.
    // ------------------------------------------------------------------
    assign w_period_m1 = (32'(STEP_BASE) >> speed) - 32'd1;
    assign w_cnt_ext   = 32'(r_cnt);
    assign w_terminal  = (w_cnt_ext >= w_period_m1);

    // ------------------------------------------------------------------
    // Length of the message currently on the datapath and the candidate
    // offset for an advance in either direction.
    // ------------------------------------------------------------------
    assign w_len          = msg_sel ? msg_len_b : msg_len_a;
    assign w_len_m1       = w_len - C_LEN_ONE;
    // Also true for an empty message, which pins the offset at 0 and
    // suppresses every advance and strobe.
    assign w_out_of_range = (offset >= w_len);

    always_comb begin
        w_adv_offset = offset;
        w_adv_wrap   = 1'b0;
        if (!dir) begin
            if (offset == w_len_m1) begin
                w_adv_offset = '0;
                w_adv_wrap   = 1'b1;
            end else begin
                w_adv_offset = offset + C_LEN_ONE;
            end
        end else begin
            if (offset == '0) begin
                w_adv_offset = w_len_m1;
                w_adv_wrap   = 1'b1;
            end else begin
                w_adv_offset = offset - C_LEN_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic.
    // ------------------------------------------------------------------
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_cnt    = r_cnt;
        w_nxt_offset = offset;
        w_nxt_sel    = msg_sel;
        w_nxt_tick   = 1'b0;
        w_nxt_wrap   = 1'b0;
        w_adv_req    = 1'b0;

        case (r_state)
            ST_SWITCH: begin
                // The new select is loaded here, so the message-change check
                // is not applied in this state; a further toggle of
                // sel_student is caught on the following cycle.
                w_nxt_sel   = sel_student;
                w_nxt_cnt   = '0;
                w_nxt_state = scroll_en ? ST_RUN : ST_HOLD;
            end
            ST_RUN: begin
                if (sel_student != msg_sel) begin
                    w_nxt_state = ST_SWITCH;
                end else begin
                    // A terminal count still advances even when scroll_en
                    // drops in the same cycle.
                    if (w_terminal) begin
                        w_adv_req = 1'b1;
                        w_nxt_cnt = '0;
                    end else if (scroll_en) begin
                        w_nxt_cnt = r_cnt + C_CNT_ONE;
                    end
                    if (!scroll_en) begin
                        w_nxt_state = ST_HOLD;
                    end
                end
            end
            default: begin
                // HOLD: cnt is frozen so a resume keeps the step phase.
                if (sel_student != msg_sel) begin
                    w_nxt_state = ST_SWITCH;
                end else if (scroll_en) begin
                    w_nxt_state = ST_RUN;
                end else if (step_pulse) begin
                    w_adv_req = 1'b1;
                end
            end
        endcase

        if (r_state == ST_SWITCH || w_out_of_range) begin
            w_nxt_offset = '0;
        end else if (w_adv_req) begin
            w_nxt_offset = w_adv_offset;
            w_nxt_tick   = 1'b1;
            w_nxt_wrap   = w_adv_wrap;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_HOLD;
            r_cnt     <= '0;
            offset    <= '0;
            msg_sel   <= 1'b0;
            step_tick <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_cnt     <= w_nxt_cnt;
            offset    <= w_nxt_offset;
            msg_sel   <= w_nxt_sel;
            step_tick <= w_nxt_tick;
            wrap      <= w_nxt_wrap;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scroll_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scroll_sequencer
// Description : Self-checking bench for scroll_sequencer. A behavioural
//               reference model predicts the outputs of every clock edge and
//               queues them; the queue is popped and compared after the edge.
//               Directed checks pin down the key scenarios explicitly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scroll_sequencer;

    localparam int unsigned C_STEP_BASE = 8;
    localparam int unsigned C_LEN_W     = 5;

    logic               clk;
    logic               rst;
    logic               scroll_en;
    logic               sel_student;
    logic [C_LEN_W-1:0] msg_len_a;
    logic [C_LEN_W-1:0] msg_len_b;
    logic [1:0]         speed;
    logic               dir;
    logic               step_pulse;
    logic [C_LEN_W-1:0] offset;
    logic               msg_sel;
    logic               step_tick;
    logic               wrap;

    scroll_sequencer #(
        .STEP_BASE (C_STEP_BASE),
        .LEN_W     (C_LEN_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .scroll_en   (scroll_en),
        .sel_student (sel_student),
        .msg_len_a   (msg_len_a),
        .msg_len_b   (msg_len_b),
        .speed       (speed),
        .dir         (dir),
        .step_pulse  (step_pulse),
        .offset      (offset),
        .msg_sel     (msg_sel),
        .step_tick   (step_tick),
        .wrap        (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [C_LEN_W-1:0] off;
        logic               sel;
        logic               tick;
        logic               wrp;
    } exp_t;

    exp_t q_exp[$];

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: 0 = HOLD, 1 = RUN, 2 = SWITCH
    int m_state = 0;
    int m_cnt   = 0;
    int m_off   = 0;
    int m_sel   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Predicts the outcome of the coming clock edge from the present inputs.
    task automatic model_edge();
        int   len;
        int   period;
        bit   adv;
        exp_t e;
        e.tick = 1'b0;
        e.wrp  = 1'b0;
        adv    = 1'b0;
        len    = m_sel ? int'(msg_len_b) : int'(msg_len_a);
        if (rst) begin
            m_state = 0; m_cnt = 0; m_off = 0; m_sel = 0;
        end else if (m_state == 2) begin
            m_sel   = int'(sel_student);
            m_off   = 0;
            m_cnt   = 0;
            m_state = scroll_en ? 1 : 0;
        end else begin
            if (int'(sel_student) != m_sel) begin
                m_state = 2;
            end else if (m_state == 1) begin
                period = int'(C_STEP_BASE >> speed);
                if (m_cnt >= period - 1) begin
                    adv   = 1'b1;
                    m_cnt = 0;
                end else if (scroll_en) begin
                    m_cnt = m_cnt + 1;
                end
                if (!scroll_en) m_state = 0;
            end else begin
                if (scroll_en) m_state = 1;
                else if (step_pulse) adv = 1'b1;
            end
            if (m_off >= len) begin
                m_off = 0;
            end else if (adv) begin
                e.tick = 1'b1;
                if (!dir) begin
                    e.wrp = (m_off == len - 1);
                    m_off = (m_off + 1) % len;
                end else begin
                    e.wrp = (m_off == 0);
                    m_off = (m_off + len - 1) % len;
                end
            end
        end
        e.off = m_off[C_LEN_W-1:0];
        e.sel = m_sel[0];
        q_exp.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        n_assert++;
        assert (q_exp.size() > 0) else begin
            n_fail++;
            $error("FAIL sb_empty: observed %0d expected >0", q_exp.size());
        end
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            chk("sb_offset",    int'(offset),    int'(e.off));
            chk("sb_msg_sel",   int'(msg_sel),   int'(e.sel));
            chk("sb_step_tick", int'(step_tick), int'(e.tick));
            chk("sb_wrap",      int'(wrap),      int'(e.wrp));
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            model_edge();
            @(posedge clk);
            #1;
            sb_check();
        end
    endtask

    initial begin
        int ticks;
        rst = 1'b1; scroll_en = 1'b0; sel_student = 1'b0;
        msg_len_a = 5'd4; msg_len_b = 5'd6;
        speed = 2'd0; dir = 1'b0; step_pulse = 1'b0;
        #1;
        tick_n(2);
        chk("reset_offset",  int'(offset),    0);
        chk("reset_msg_sel", int'(msg_sel),   0);
        chk("reset_tick",    int'(step_tick), 0);
        chk("reset_wrap",    int'(wrap),      0);

        // Free-running, P=8, incrementing: 0,1,2,3,0
        rst = 1'b0; scroll_en = 1'b1;
        tick_n(8);
        chk("run_first_tick_early", int'(step_tick), 0);
        tick_n(1);
        chk("run_first_off", int'(offset), 1);
        chk("run_first_tick", int'(step_tick), 1);
        tick_n(24);
        chk("run_wrap_off",  int'(offset), 0);
        chk("run_wrap_flag", int'(wrap),   1);

        // P=2, decrementing: 0,3,2,1,0
        speed = 2'd2; dir = 1'b1;
        tick_n(2);
        chk("dec_wrap_off",  int'(offset), 3);
        chk("dec_wrap_flag", int'(wrap),   1);
        tick_n(6);
        chk("dec_end_off",   int'(offset), 0);
        chk("dec_end_nowrap", int'(wrap),  0);

        // cnt=5 at speed 0, then jump to speed 3: immediate advance
        speed = 2'd0; dir = 1'b0;
        tick_n(5);
        speed = 2'd3;
        tick_n(1);
        chk("speed_jump_tick", int'(step_tick), 1);
        chk("speed_jump_off",  int'(offset),    1);
        speed = 2'd0;

        // Reach offset 2 with cnt 5, pause, single-step three times
        tick_n(8);
        chk("pre_pause_off", int'(offset), 2);
        tick_n(5);
        scroll_en = 1'b0;
        tick_n(1);
        step_pulse = 1'b1; tick_n(1);
        chk("step1_off", int'(offset), 3);
        step_pulse = 1'b0; tick_n(1);
        chk("step_idle_tick", int'(step_tick), 0);
        step_pulse = 1'b1; tick_n(1);
        chk("step2_off",  int'(offset), 0);
        chk("step2_wrap", int'(wrap),   1);
        tick_n(1);
        chk("step3_off",  int'(offset), 1);
        step_pulse = 1'b0;
        // Resume: cnt continues from 5
        scroll_en = 1'b1;
        tick_n(3);
        chk("resume_early_tick", int'(step_tick), 0);
        tick_n(1);
        chk("resume_tick", int'(step_tick), 1);
        chk("resume_off",  int'(offset),    2);

        // Message switch during RUN
        tick_n(1);
        sel_student = 1'b1;
        tick_n(1);
        chk("switch_pending_sel", int'(msg_sel), 0);
        tick_n(1);
        chk("switch_sel",  int'(msg_sel),   1);
        chk("switch_off",  int'(offset),    0);
        chk("switch_tick", int'(step_tick), 0);
        tick_n(7);
        chk("switch_wait_tick", int'(step_tick), 0);
        tick_n(1);
        chk("switch_adv_tick", int'(step_tick), 1);
        chk("switch_adv_off",  int'(offset),    1);

        // Back to A (length 6) while paused, step up to offset 5, shrink
        scroll_en = 1'b0; sel_student = 1'b0; msg_len_a = 5'd6;
        tick_n(2);
        chk("back_to_a_sel", int'(msg_sel), 0);
        step_pulse = 1'b1;
        tick_n(5);
        step_pulse = 1'b0;
        chk("pre_shrink_off", int'(offset), 5);
        msg_len_a = 5'd3;
        tick_n(1);
        chk("shrink_off",  int'(offset),    0);
        chk("shrink_wrap", int'(wrap),      0);
        chk("shrink_tick", int'(step_tick), 0);

        // Empty message: no advances for 50 cycles
        msg_len_a = 5'd0; scroll_en = 1'b1;
        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            tick_n(1);
            if (step_tick === 1'b1) ticks++;
        end
        chk("empty_tick_count", ticks, 0);

        // Reset mid-RUN with sel_student=1
        msg_len_a = 5'd4; sel_student = 1'b1;
        tick_n(5);
        rst = 1'b1;
        tick_n(1);
        chk("midrst_offset",  int'(offset),    0);
        chk("midrst_msg_sel", int'(msg_sel),   0);
        chk("midrst_tick",    int'(step_tick), 0);
        chk("midrst_wrap",    int'(wrap),      0);
        rst = 1'b0;
        tick_n(1);
        chk("postrst_sel_1", int'(msg_sel), 0);
        tick_n(1);
        chk("postrst_sel_2", int'(msg_sel), 1);

        // Randomised traffic checked against the model
        for (int i = 0; i < 400; i++) begin
            step_pulse = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) scroll_en = ~scroll_en;
            if ($urandom_range(0, 15) == 0) speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            if ($urandom_range(0, 31) == 0) sel_student = ~sel_student;
            if ($urandom_range(0, 19) == 0) msg_len_a = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) msg_len_b = 5'($urandom_range(0, 7));
            rst = ($urandom_range(0, 99) == 0);
            tick_n(1);
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
